// File: rtl/div32_pkg.sv
// -----------------------------------------------------------------------------
// div32_pkg
// Shared definitions for the div_32 sequential restoring divider:
//   - div_state_t / ST_* : FSM state encoding (IDLE, CALC, FIX)
//   - ITER               : number of quotient bits produced, one per cycle
//   - DIV_ZERO_Q         : quotient reported for a zero divisor
//   - neg32()            : two's-complement negator, used for the magnitude
//                          conversion and the sign fix (never the adder)
// -----------------------------------------------------------------------------
package div32_pkg;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_CALC = 2'd1;
    localparam div_state_t ST_FIX  = 2'd2;

    localparam int          ITER       = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/div_32_adc32.sv
// -----------------------------------------------------------------------------
// div_32_adc32  (the ADC32 adder)
// 33-bit result carry-in adder: s_o = a_i + b_i + c0_i.
//   a_i  [31:0] in   operand A
//   b_i  [31:0] in   operand B
//   c0_i        in   carry in
//   s_o  [32:0] out  sum, s_o[32] is the carry out
// -----------------------------------------------------------------------------
module div_32_adc32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c0_i,
    output logic [32:0] s_o
);

    assign s_o = {1'b0, a_i} + {1'b0, b_i} + {32'd0, c0_i};

endmodule

// File: rtl/div_32.sv
// -----------------------------------------------------------------------------
// div_32
// Sequential 32-bit restoring divider, one quotient bit per cycle, using the
// ADC32 adder in subtract mode (A = partial remainder, B = ~divisor, C0 = 1)
// as its trial-subtract engine.
//
// Build option: define DIV32_SIGNED_EN to honour sgn (signed operands,
// magnitude conversion at load, extra FIX state, latency 33). Without it all
// arithmetic is unsigned and latency is 32. Divide-by-zero answers in 1 cycle.
//
// Handshake: start is sampled only while the FSM is IDLE (this includes the
// done cycle, so back-to-back issue works). busy is high from the sampling
// edge until the edge that raises done; done is a one-cycle pulse and the
// quotient/remainder/div_zero outputs are valid from that cycle and held until
// they are next written.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, sgn            request pulse, signed-operand select
//   dividend, divisor     operands, sampled with start
//   busy, done            in-progress flag, completion pulse
//   quotient, remainder   registered results
//   div_zero              divisor was zero, held with the results
//   dbg_state             current FSM state (debug)
// -----------------------------------------------------------------------------
module div_32
    import div32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero,
    output div_state_t  dbg_state
);

    div_state_t  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] r_q, r_d;         // partial remainder
    logic [31:0] q_q, q_d;         // dividend shifting out / quotient shifting in
    logic [31:0] d_q, d_d;         // divisor (magnitude)
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        dz_q, dz_d;
    logic        done_q, done_d;
    logic        zpend_q, zpend_d; // divide-by-zero answer waiting for its done edge

    logic [32:0] sh;
    logic [32:0] sum;
    logic        borrow;
    logic        qbit;
    logic [31:0] r_step;
    logic [31:0] q_step;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

`ifdef DIV32_SIGNED_EN
    logic negq_q, negq_d;          // quotient negated when operand signs differ
    logic negr_q, negr_d;          // remainder follows the dividend's sign

    assign mag_a = (sgn && dividend[31]) ? neg32(dividend) : dividend;
    assign mag_b = (sgn && divisor[31])  ? neg32(divisor)  : divisor;
`else
    logic sgn_unused;
    assign sgn_unused = sgn;
    assign mag_a      = dividend;
    assign mag_b      = divisor;
`endif

    // Trial subtract: sum = sh[31:0] - D + 2^32, so the carry out is the
    // inverse of the borrow.
    assign sh = {r_q, q_q[31]};

    div_32_adc32 u_adc32 (
        .a_i  (sh[31:0]),
        .b_i  (~d_q),
        .c0_i (1'b1),
        .s_o  (sum)
    );

    assign borrow = ~sum[32];
    // sh[32] set means sh >= 2^32 > D: the subtract always succeeds even
    // though the 32-bit adder reports a borrow.
    assign qbit   = sh[32] | ~borrow;
    assign r_step = qbit ? sum[31:0] : sh[31:0];
    assign q_step = {q_q[30:0], qbit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        zpend_d = 1'b0;
`ifdef DIV32_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (zpend_q) begin
                    // Results were written on the sampling edge; raise done now.
                    done_d = 1'b1;
                end else if (start) begin
                    if (divisor == 32'd0) begin
                        quot_d  = DIV_ZERO_Q;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                        zpend_d = 1'b1;
                    end else begin
                        r_d     = 32'd0;
                        q_d     = mag_a;
                        d_d     = mag_b;
                        cnt_d   = 6'd0;
                        dz_d    = 1'b0;
                        state_d = ST_CALC;
`ifdef DIV32_SIGNED_EN
                        negq_d  = sgn & (dividend[31] ^ divisor[31]);
                        negr_d  = sgn & dividend[31];
`endif
                    end
                end
            end
            ST_CALC: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1)) begin
`ifdef DIV32_SIGNED_EN
                    state_d = ST_FIX;
`else
                    quot_d  = q_step;
                    rem_d   = r_step;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef DIV32_SIGNED_EN
            ST_FIX: begin
                quot_d  = negq_q ? neg32(q_q) : q_q;
                rem_d   = negr_q ? neg32(r_q) : r_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            r_q     <= 32'd0;
            q_q     <= 32'd0;
            d_q     <= 32'd0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            zpend_q <= 1'b0;
`ifdef DIV32_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            zpend_q <= zpend_d;
`ifdef DIV32_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_32.sv
module tb_div_32;
    import div32_pkg::*;

`ifdef DIV32_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;
    div_state_t  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    div_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sgn       (sgn),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s && SIGNED_BUILD) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
            sa = a;
            sb = b;
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
        return (b == 32'd0) ? 1 : (SIGNED_BUILD ? 33 : 32);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        sgn      = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the sampling edge to done; optionally pulses a
    // spurious start (100 / 7) so that it is sampled at edge inj+1.
    task automatic wait_done(input bit exp_busy, input int inj, output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== exp_busy) busy_ok = 1'b0;
            if (lat == inj) begin
                start    = 1'b1;
                dividend = 32'd100;
                divisor  = 32'd7;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_zero}); end
        checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        launch(32'd100, 32'd7, 1'b0);
        wait_done(1'b1, -1, lat, bok);
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_q got=%0d exp=14", quotient); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL basic_r got=%0d exp=2", remainder); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL basic_dz got=%b exp=0", div_zero); end
        checks++; if (lat != ref_lat(32'd7)) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, ref_lat(32'd7)); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bok); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", done); end
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_hold got=%0d exp=14", quotient); end
    endtask

    task automatic test_r31();
        logic [31:0] a_t[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b_t[2] = '{32'h8000_0001, 32'h0000_0001};
        logic [31:0] q_t[2] = '{32'h0000_0001, 32'hFFFF_FFFF};
        logic [31:0] r_t[2] = '{32'h7FFF_FFFE, 32'h0000_0000};
        int lat;
        bit bok;
        for (int i = 0; i < 2; i++) begin
            launch(a_t[i], b_t[i], 1'b0);
            wait_done(1'b1, -1, lat, bok);
            checks++; if (quotient !== q_t[i]) begin errors++; $display("FAIL r31_q[%0d] got=%h exp=%h", i, quotient, q_t[i]); end
            checks++; if (remainder !== r_t[i]) begin errors++; $display("FAIL r31_r[%0d] got=%h exp=%h", i, remainder, r_t[i]); end
            checks++; if (lat != ref_lat(b_t[i])) begin errors++; $display("FAIL r31_latency[%0d] got=%0d exp=%0d", i, lat, ref_lat(b_t[i])); end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        bit bok;
        launch(32'd1234, 32'd0, 1'b0);
        wait_done(1'b0, -1, lat, bok);
        checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q got=%h exp=ffffffff", quotient); end
        checks++; if (remainder !== 32'd1234) begin errors++; $display("FAIL dz_r got=%0d exp=1234", remainder); end
        checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
        checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL dz_busy_low got=%b exp=1", bok); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL dz_done_width got=%b exp=0", done); end
    endtask

    task automatic test_ignore_start();
        int lat;
        bit bok;
        launch(32'd50, 32'd3, 1'b0);
        wait_done(1'b1, 4, lat, bok);
        checks++; if (quotient !== 32'd16) begin errors++; $display("FAIL ignore_q got=%0d exp=16", quotient); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL ignore_r got=%0d exp=2", remainder); end
        checks++; if (lat != ref_lat(32'd3)) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, ref_lat(32'd3)); end
    endtask

    task automatic test_reset_midop();
        int lat;
        bit bok;
        bit seen;
        launch(32'd200, 32'd9, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL abort_flags got=%b exp=000", {busy, done, div_zero}); end
        checks++; if ({quotient, remainder} !== 64'd0) begin errors++; $display("FAIL abort_results got=%h exp=0", {quotient, remainder}); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL abort_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", seen); end
        launch(32'd9, 32'd3, 1'b0);
        wait_done(1'b1, -1, lat, bok);
        checks++; if ({quotient, remainder} !== {32'd3, 32'd0}) begin errors++; $display("FAIL after_abort got=%0d r %0d exp=3 r 0", quotient, remainder); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first_b[2] = '{32'd10, 32'd0};
        int lat;
        bit bok;
        for (int i = 0; i < 2; i++) begin
            launch(32'd1000, first_b[i], 1'b0);
            wait_done(first_b[i] != 32'd0, -1, lat, bok);
            // Now inside the done cycle: issue the next request immediately.
            start    = 1'b1;
            dividend = 32'd20;
            divisor  = 32'd6;
            sgn      = 1'b0;
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_done(1'b1, -1, lat, bok);
            checks++; if ({quotient, remainder} !== {32'd3, 32'd2}) begin errors++; $display("FAIL b2b_result[%0d] got=%0d r %0d exp=3 r 2", i, quotient, remainder); end
            checks++; if (lat != ref_lat(32'd6)) begin errors++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, ref_lat(32'd6)); end
            checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL b2b_dz_clear[%0d] got=%b exp=0", i, div_zero); end
            checks++; if (bok !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got=%b exp=1", i, bok); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
        int lat;
        bit bok;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = 32'd0;
                default: b = 32'h8000_0000 | $urandom;
            endcase
            exp_q.push_back(ref_div(a, b, s));
            launch(a, b, s);
            wait_done(b != 32'd0, -1, lat, bok);
            exp = exp_q.pop_front();
            checks++; if ({quotient, remainder} !== exp) begin errors++; $display("FAIL rand_result[%0d] %h/%h s=%b got=%h_%h exp=%h", i, a, b, s, quotient, remainder, exp); end
            checks++; if (div_zero !== (b == 32'd0)) begin errors++; $display("FAIL rand_dz[%0d] got=%b exp=%b", i, div_zero, b == 32'd0); end
            checks++; if (lat != ref_lat(b)) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, ref_lat(b)); end
        end
    endtask

`ifdef DIV32_SIGNED_EN
    task automatic test_signed();
        logic [31:0] a_t[4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFF8};
        logic [31:0] b_t[4] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000};
        logic [31:0] q_t[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        logic [31:0] r_t[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFF8};
        int l_t[4] = '{33, 33, 33, 1};
        int lat;
        bit bok;
        for (int i = 0; i < 4; i++) begin
            launch(a_t[i], b_t[i], 1'b1);
            wait_done(b_t[i] != 32'd0, -1, lat, bok);
            checks++; if ({quotient, remainder} !== {q_t[i], r_t[i]}) begin errors++; $display("FAIL signed[%0d] got=%h_%h exp=%h_%h", i, quotient, remainder, q_t[i], r_t[i]); end
            checks++; if (lat != l_t[i]) begin errors++; $display("FAIL signed_latency[%0d] got=%0d exp=%0d", i, lat, l_t[i]); end
        end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_r31();
        test_div_zero();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        test_random();
`ifdef DIV32_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
